// File: rtl/signed_sat_accum_pkg.sv
// Shared types and saturation limits for the signed saturating frame accumulator.
package signed_sat_accum_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    function automatic int smax(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int smin(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int DEF_WIDTH = 4;
    localparam int SMAX      = smax(DEF_WIDTH);
    localparam int SMIN      = smin(DEF_WIDTH);

endpackage

// File: rtl/signed_sat_add.sv
// Combinational signed add that clamps to the representable rail on overflow.
module signed_sat_add
    import signed_sat_accum_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(smin(WIDTH));

    logic [WIDTH-1:0] s;

    assign s   = a + b;
    // Overflow only possible when operands share a sign and the sum flips it.
    assign ovf = (a[MSB] == b[MSB]) && (s[MSB] != a[MSB]);
    assign res = ovf ? (a[MSB] ? SAT_LO : SAT_HI) : s;

endmodule

// File: rtl/signed_sat_accum.sv
// Frame accumulator: sums N signed samples with saturation, emits the result on valid/ready.
module signed_sat_accum
    import signed_sat_accum_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_sum,
    output logic             down_sat
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             sat_flag;
    logic [WIDTH-1:0] add_res;
    logic             add_ovf;
    logic             hs_in, hs_out, last;

    signed_sat_add #(.WIDTH(WIDTH)) u_add (
        .a   (acc),
        .b   (up_data),
        .res (add_res),
        .ovf (add_ovf)
    );

    assign up_ready   = (state == ACC);
    assign down_valid = (state == OUT);
    assign hs_in      = up_valid && up_ready;
    assign hs_out     = down_valid && down_ready;
    assign last       = (cnt == CW'(N - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ACC: if (hs_in && last) state_nxt = OUT;
            OUT: if (hs_out)        state_nxt = ACC;
            default:                state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // Final sample goes straight to the output registers; accumulator restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            down_sum <= '0;
            down_sat <= 1'b0;
        end else if (hs_in) begin
            if (last) begin
                down_sum <= add_res;
                down_sat <= sat_flag | add_ovf;
                acc      <= '0;
                cnt      <= '0;
                sat_flag <= 1'b0;
            end else begin
                acc      <= add_res;
                cnt      <= cnt + CW'(1);
                sat_flag <= sat_flag | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_signed_sat_accum.sv
// Randomized + directed bench for signed_sat_accum against an integer frame model.
module tb_signed_sat_accum;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [W-1:0] up_data = '0;
    logic         down_valid;
    logic         down_ready = 1'b0;
    logic [W-1:0] down_sum;
    logic         down_sat;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending samples of the current frame and any undelivered result.
    int           q[$];
    bit           m_out = 1'b0;
    logic [W-1:0] m_sum = '0;
    bit           m_sat = 1'b0;

    signed_sat_accum #(.WIDTH(W), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_sum   (down_sum),
        .down_sat   (down_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic close_frame();
        int a;
        bit s;
        a = 0;
        s = 1'b0;
        foreach (q[i]) begin
            a = a + q[i];
            if (a > HI) begin a = HI; s = 1'b1; end
            if (a < LO) begin a = LO; s = 1'b1; end
        end
        q.delete();
        m_out = 1'b1;
        m_sum = W'(a);
        m_sat = s;
    endtask

    // One clock: drive, check at negedge, advance model for the coming edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        up_valid   = v;
        up_data    = d;
        down_ready = r;
        @(negedge clk);
        chk("up_ready", {7'd0, up_ready}, {7'd0, !m_out});
        chk("down_valid", {7'd0, down_valid}, {7'd0, m_out});
        if (m_out) begin
            chk("down_sum", {4'd0, down_sum}, {4'd0, m_sum});
            chk("down_sat", {7'd0, down_sat}, {7'd0, m_sat});
        end
        if (!m_out && v) begin
            q.push_back(int'($signed(d)));
            if (q.size() == N) close_frame();
        end else if (m_out && r) begin
            m_out = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_dv", {7'd0, down_valid}, 8'd0);
        chk("rst_sum", {4'd0, down_sum}, 8'd0);
        chk("rst_sat", {7'd0, down_sat}, 8'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", {7'd0, up_ready}, 8'd1);
        q.delete();
        m_out = 1'b0;
    endtask

    // Feeds four samples back-to-back, then checks the result against a literal.
    task automatic frame(input int a, input int b, input int c, input int d,
                         input int esum, input bit esat);
        logic [W-1:0] e;
        step(1'b1, W'(a), 1'b1);
        step(1'b1, W'(b), 1'b1);
        step(1'b1, W'(c), 1'b1);
        step(1'b1, W'(d), 1'b1);
        e = W'(esum);
        chk("frm_dv", {7'd0, down_valid}, 8'd1);
        chk("frm_sum", {4'd0, down_sum}, {4'd0, e});
        chk("frm_sat", {7'd0, down_sat}, {7'd0, esat});
    endtask

    initial begin
        bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};

        #3;
        chk("init_dv", {7'd0, down_valid}, 8'd0);
        chk("init_sum", {4'd0, down_sum}, 8'd0);
        chk("init_sat", {7'd0, down_sat}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        frame(1, 2, 3, 1, 7, 1'b0);
        step(1'b0, '0, 1'b1);
        frame(5, 5, -3, 1, 5, 1'b1);
        step(1'b0, '0, 1'b1);
        frame(-8, -1, 0, 0, -8, 1'b1);
        step(1'b0, '0, 1'b1);
        frame(7, 1, 0, 0, 7, 1'b1);
        step(1'b0, '0, 1'b1);

        // Held result while upstream keeps pushing.
        frame(1, 1, 1, 1, 4, 1'b0);
        repeat (3) step(1'b1, W'(2), 1'b0);
        step(1'b1, W'(2), 1'b1);
        frame(2, 2, 2, -1, 5, 1'b0);
        step(1'b0, '0, 1'b1);

        // Bubbles between valid samples.
        foreach (pat[i]) step(pat[i], W'(1), 1'b1);
        step(1'b0, '0, 1'b1);

        // Reset mid-frame, then while a result is pending.
        step(1'b1, W'(3), 1'b1);
        step(1'b1, W'(3), 1'b1);
        async_reset();
        frame(2, 2, 2, 2, 7, 1'b1);
        async_reset();
        frame(1, 1, 1, 1, 4, 1'b0);
        step(1'b0, '0, 1'b1);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 79) == 0) async_reset();
            step(($urandom_range(0, 3) != 0), W'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
